mips8_controller: RTL and testbench

//  Multicycle control FSM for the 8-bit MIPS datapath (ALU, regfile, PC, IR, byte memory).

---
 rtl/mips8_controller.sv | 184 ++++++++++++++++++
 tb/tb_mips8_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips8_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: byte-wise fetch, decode, execute.
// Memory states (fetch, LB read, SB write) stall on mem_ready; outputs are a pure function of state and inputs.
module mips8_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Next-state logic: memory states only advance when the access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1:  if (mem_ready) state_d = S_FETCH2;
      S_FETCH2:  if (mem_ready) state_d = S_FETCH3;
      S_FETCH3:  if (mem_ready) state_d = S_FETCH4;
      S_FETCH4:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LB:   state_d = S_LBRD;
          OP_SB:   state_d = S_SBWR;
          default: state_d = S_FETCH1;
        endcase
      end
      S_LBRD:    if (mem_ready) state_d = S_LBWR;
      S_LBWR:    state_d = S_FETCH1;
      S_SBWR:    if (mem_ready) state_d = S_FETCH1;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_RTYPEWR: state_d = S_FETCH1;
      S_BEQEX:   state_d = S_FETCH1;
      S_JEX:     state_d = S_FETCH1;
      S_ADDIEX:  state_d = S_ADDIWR;
      S_ADDIWR:  state_d = S_FETCH1;
      default:   state_d = S_FETCH1;
    endcase
  end

  // Output decode; irwrite and pcen in fetch are gated by mem_ready so a stall never double-loads.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 4'b0000;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    pcen       = 1'b0;
    alucontrol = ALU_ADD;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcen    = mem_ready;
        case (state_q)
          S_FETCH1: irwrite = {3'b000, mem_ready};
          S_FETCH2: irwrite = {2'b00, mem_ready, 1'b0};
          S_FETCH3: irwrite = {1'b0, mem_ready, 2'b00};
          default:  irwrite = {mem_ready, 3'b000};
        endcase
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      S_RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsource   = 2'b01;
        pcen       = zero;
      end
      S_JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWR: begin
        regwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips8_controller.sv
// Bench for mips8_controller: per-instruction state path model plus a per-state control table,
// exercised with directed instructions and randomized ops, stalls and zero flags.
module tb_mips8_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       memread, memwrite, iord, memtoreg, regdst, regwrite, alusrca, pcen;
  logic [3:0] irwrite;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips8_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsource(pcsource), .pcen(pcen), .alucontrol(alucontrol),
    .state(state)
  );

  // Required ALU code for an R-type funct field.
  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Whole-instruction cycle count with memory always ready.
  function automatic int latency_of(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000: return 7;
      6'b000000: return 7;
      6'b001000: return 7;
      6'b000100: return 6;
      6'b000010: return 6;
      default:   return 5;
    endcase
  endfunction

  function automatic bit is_mem_state(input int s);
    return (s <= 3) || (s == 6) || (s == 8);
  endfunction

  // Control word order: memread memwrite iord irwrite[4] memtoreg regdst regwrite alusrca alusrcb[2] pcsource[2] pcen alucontrol[3]
  function automatic logic [18:0] exp_ctrl(input int s, input logic [5:0] f, input logic z, input logic r);
    logic mr, mw, io, mtr, rd, rw, sa, pe;
    logic [3:0] irw;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    mr = 0; mw = 0; io = 0; mtr = 0; rd = 0; rw = 0; sa = 0; pe = 0;
    irw = 4'b0000; sb = 2'b00; ps = 2'b00; ac = 3'b010;
    if (s <= 3) begin
      mr = 1; sb = 2'b01; pe = r;
      irw[s] = r;
    end else begin
      case (s)
        4:  sb = 2'b11;
        5:  begin sa = 1; sb = 2'b10; end
        6:  begin mr = 1; io = 1; end
        7:  begin rw = 1; mtr = 1; end
        8:  begin mw = 1; io = 1; end
        9:  begin sa = 1; ac = alu_of_funct(f); end
        10: begin rw = 1; rd = 1; end
        11: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
        12: begin ps = 2'b10; pe = 1; end
        13: begin sa = 1; sb = 2'b10; end
        14: rw = 1;
        default: ;
      endcase
    end
    return {mr, mw, io, irw, mtr, rd, rw, sa, sb, ps, pe, ac};
  endfunction

  task automatic check_state(input string tag, input int exp_s);
    n_cmp++;
    assert (state === 4'(exp_s)) else begin
      n_fail++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, exp_s);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [18:0] exp_c);
    logic [18:0] act;
    act = {memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite, alusrca,
           alusrcb, pcsource, pcen, alucontrol};
    n_cmp++;
    assert (act === exp_c) else begin
      n_fail++;
      $error("FAIL %s ctrl (state %0d): got %b expected %b", tag, state, act, exp_c);
    end
  endtask

  // Runs one instruction from FETCH1. rdy_pct: chance mem_ready=1 per cycle; hold_st/hold_n force
  // hold_n stall cycles in one state; abort_st asserts reset while in that state; exp_lat<=0 skips latency check.
  task automatic run_instr(input string tag, input logic [5:0] op_v, input logic [5:0] funct_v,
                           input logic zero_v, input int rdy_pct, input int hold_st,
                           input int hold_n, input int abort_st, input int exp_lat);
    int path[$];
    int cyc, cur, holds;
    path = {0, 1, 2, 3, 4};
    case (op_v)
      6'b100000: path = {path, 5, 6, 7};
      6'b101000: path = {path, 5, 8};
      6'b000000: path = {path, 9, 10};
      6'b000100: path = {path, 11};
      6'b000010: path = {path, 12};
      6'b001000: path = {path, 13, 14};
      default: ;
    endcase
    op = op_v; funct = funct_v; zero = zero_v;
    cyc = 0; holds = hold_n;
    while (path.size() > 0 && cyc < 200) begin
      cur = path[0];
      mem_ready = (int'($urandom_range(99)) < rdy_pct);
      if (cur == hold_st && holds > 0) begin
        mem_ready = 1'b0;
        holds--;
      end
      if (cur == abort_st) reset = 1'b1;
      @(negedge clk);
      check_state(tag, cur);
      check_ctrl(tag, exp_ctrl(cur, funct_v, zero_v, mem_ready));
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        path.delete();
        reset = 1'b0;
      end else if (!(is_mem_state(cur) && !mem_ready)) begin
        void'(path.pop_front());
      end
    end
    if (path.size() > 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s timeout: got %0d cycles expected completion", tag, cyc);
    end
    if (exp_lat > 0) begin
      n_cmp++;
      assert (cyc == exp_lat) else begin
        n_fail++;
        $error("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_lat);
      end
    end
  endtask

  initial begin
    logic [5:0] op_list[7];
    logic [5:0] funct_list[6];
    logic [5:0] o, f;
    op_list    = '{6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    funct_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    // Reset held two cycles with memory idle.
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_state("reset_held", 0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_state("reset_rel", 0);
    check_ctrl("reset_rel", exp_ctrl(0, 6'd0, 1'b0, 1'b0));
    @(posedge clk); #1;

    // Directed instructions with memory always ready, including latency checks.
    run_instr("addi",      6'b001000, 6'b000000, 1'b0, 100, -1, 0, -1, latency_of(6'b001000));
    run_instr("lb",        6'b100000, 6'b000000, 1'b0, 100, -1, 0, -1, latency_of(6'b100000));
    run_instr("lb_stall",  6'b100000, 6'b000000, 1'b0, 100,  6, 3, -1, latency_of(6'b100000) + 3);
    run_instr("sb",        6'b101000, 6'b000000, 1'b0, 100, -1, 0, -1, latency_of(6'b101000));
    run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 100, -1, 0, -1, latency_of(6'b000100));
    run_instr("beq_not",   6'b000100, 6'b000000, 1'b0, 100, -1, 0, -1, latency_of(6'b000100));
    run_instr("rtype_slt", 6'b000000, 6'b101010, 1'b0, 100, -1, 0, -1, latency_of(6'b000000));
    run_instr("rtype_or",  6'b000000, 6'b100101, 1'b0, 100, -1, 0, -1, latency_of(6'b000000));
    run_instr("jump",      6'b000010, 6'b000000, 1'b0, 100, -1, 0, -1, latency_of(6'b000010));
    run_instr("illegal",   6'b111111, 6'b000000, 1'b0, 100, -1, 0, -1, latency_of(6'b111111));
    run_instr("fetch_stall", 6'b001000, 6'b000000, 1'b0, 100, 2, 2, -1, latency_of(6'b001000) + 2);

    // Reset while stalled in SBWR aborts the store.
    run_instr("sb_abort",  6'b101000, 6'b000000, 1'b0, 100, 8, 2, 8, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    check_state("sb_abort_after", 0);
    check_ctrl("sb_abort_after", exp_ctrl(0, 6'd0, 1'b0, 1'b0));
    @(posedge clk); #1;

    // Randomized ops, functs, zero flags and memory stalls.
    for (int i = 0; i < 40; i++) begin
      o = op_list[$urandom_range(6)];
      f = funct_list[$urandom_range(5)];
      run_instr("rand", o, f, 1'($urandom_range(1)), 60, -1, 0, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
